// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine triggered by a CPU write to 0xFF46.
// Copies OAM_BYTES bytes from {src,8'h00} into OAM at OAM_BASE over the
// shared memory bus, one byte per two clocks, holding the CPU off the bus.
//
// Optional build macro: OAM_DMA_RESTART_EN
//   defined   : a dma_wr seen while busy (including the final WRITE) restarts
//               the transfer from the new source; only the final transfer
//               produces a done pulse.
//   undefined : dma_wr is ignored while busy.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   dma_wr        one-cycle pulse, CPU wrote 0xFF46
//   dma_src       source high byte, valid with dma_wr
//   busy          transfer in progress (state != IDLE)
//   bus_addr      memory address while busy, 0 otherwise
//   bus_re        read strobe (READ state)
//   bus_we        write strobe (WRITE state)
//   bus_rdata     read data, valid in the same cycle as bus_re
//   bus_wdata     write data, valid with bus_we
//   done          one-cycle pulse after the final byte is written
module oam_dma #(
  parameter int unsigned OAM_BYTES = 160,
  parameter logic [15:0] OAM_BASE  = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_wr,
  input  logic [7:0]  dma_src,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic        bus_re,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  bus_wdata,
  output logic        done
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic [7:0]         eff_src_c;
  logic               last_c;

  // Echo-RAM sources (0xE0xx and up) mirror work RAM 0x20 pages lower.
  assign eff_src_c = (src_q >= 8'hE0) ? 8'(src_q - 8'h20) : src_q;
  assign last_c    = (idx_q == IDX_W'(OAM_BYTES - 1));
  assign done      = done_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state and bus outputs; outputs depend only on registered state.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    busy      = (state_q != IDLE);
    bus_addr  = '0;
    bus_re    = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = '0;

    case (state_q)
      IDLE: begin
        if (dma_wr) begin
          src_d   = dma_src;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Dead cycle lets the CPU's FF46 write retire before we own the bus.
        state_d = READ;
      end
      READ: begin
        bus_addr = {eff_src_c, idx_q};
        bus_re   = 1'b1;
        data_d   = bus_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        bus_addr  = ADDR_W'(OAM_BASE + ADDR_W'(idx_q));
        bus_we    = 1'b1;
        bus_wdata = data_q;
        if (last_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = IDX_W'(idx_q + 1'b1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef OAM_DMA_RESTART_EN
    // Restart overrides progress; the strobe of the current cycle still goes out.
    if (dma_wr && (state_q != IDLE)) begin
      src_d   = dma_src;
      idx_d   = '0;
      done_d  = 1'b0;
      state_d = START;
    end
`endif
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma with a byte-wide
// source memory model and an OAM model fed by the DUT write strobe.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_wr;
  logic [7:0]  dma_src;
  logic        busy;
  logic [15:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic [7:0]  bus_wdata;
  logic        done;

  oam_dma dut (
    .clk       (clk),
    .rst       (rst),
    .dma_wr    (dma_wr),
    .dma_src   (dma_src),
    .busy      (busy),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .bus_wdata (bus_wdata),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Source memory (written only by the stimulus) and OAM (written only by DUT).
  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:159];
  logic        oam_clr = 1'b0;
  logic [15:0] win_lo = 16'h0000;
  logic [15:0] win_hi = 16'hFFFF;

  assign bus_rdata = mem[bus_addr];

  int cyc      = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int ovl_cnt  = 0;
  int oob_cnt  = 0;
  int rd_in    = 0;
  int rd_out   = 0;

  // Monitor: each posedge closes the cycle numbered by the old cyc value.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus_re && bus_we) ovl_cnt <= ovl_cnt + 1;
    if (bus_re) begin
      if (bus_addr >= win_lo && bus_addr <= win_hi) rd_in <= rd_in + 1;
      else rd_out <= rd_out + 1;
    end
    if (oam_clr) begin
      for (int i = 0; i < 160; i++) oam[i] <= 8'h00;
    end else if (bus_we) begin
      if (bus_addr >= 16'hFE00 && bus_addr <= 16'hFE9F)
        oam[8'(bus_addr - 16'hFE00)] <= bus_wdata;
      else
        oob_cnt <= oob_cnt + 1;
    end
  end

  int passes = 0;
  int total  = 0;
  int e0, e0a, done_base, busy_base, rin_base, rout_base, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_oam(input string tag, input logic [7:0] key);
    int errs;
    logic [7:0] ev;
    errs = 0;
    for (int i = 0; i < 160; i++) begin
      ev = 8'(i) ^ key;
      if (oam[i] !== ev) errs++;
    end
    chk(tag, 32'(errs), 32'd0);
  endtask

  task automatic clear_oam();
    oam_clr = 1'b1;
    @(negedge clk);
    oam_clr = 1'b0;
  endtask

  // Called at a negedge; the current cycle becomes E0. Returns at negedge of E0+1.
  task automatic trigger(input logic [7:0] s);
    dma_src = s;
    dma_wr  = 1'b1;
    e0      = cyc;
    @(negedge clk);
    dma_wr  = 1'b0;
    dma_src = 8'h00;
  endtask

  task automatic snapshot();
    done_base = done_cnt;
    busy_base = busy_cnt;
    rin_base  = rd_in;
    rout_base = rd_out;
  endtask

  task automatic wait_done(input string tag, input int bound);
    n = 0;
    while (done_cnt == done_base && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    dma_wr  = 1'b0;
    dma_src = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'hA5;
      mem[16'hD100 + 16'(i)] = 8'(i) ^ 8'h33;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_addr",  32'(bus_addr), 32'd0);
    chk("rst_re",    32'(bus_re), 32'd0);
    chk("rst_we",    32'(bus_we), 32'd0);
    chk("rst_wdata", 32'(bus_wdata), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    rst = 1'b0;
    clear_oam();
    @(negedge clk);

    // Basic transfer from 0xC000 with first-byte timing.
    win_lo = 16'hC000; win_hi = 16'hC09F;
    trigger(8'hC0);
    snapshot();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_strb", 32'({bus_re, bus_we}), 32'd0);
    @(negedge clk);
    chk("rd0_re",   32'(bus_re), 32'd1);
    chk("rd0_addr", 32'(bus_addr), 32'hC000);
    @(negedge clk);
    chk("wr0_we",    32'(bus_we), 32'd1);
    chk("wr0_addr",  32'(bus_addr), 32'hFE00);
    chk("wr0_wdata", 32'(bus_wdata), 32'h5A);
    wait_done("basic_timeout", 400);
    chk("basic_done_cyc", 32'(done_cyc - e0), 32'd322);
    chk("basic_done_cnt", 32'(done_cnt - done_base), 32'd1);
    chk("basic_busy_len", 32'(busy_cnt - busy_base), 32'd321);
    chk("basic_rd_cnt",   32'(rd_in - rin_base), 32'd160);
    chk_oam("basic_oam", 8'h5A);
    chk("basic_idle", 32'(busy), 32'd0);

    // Echo-RAM remap: 0xF1 reads from 0xD100.
    clear_oam();
    win_lo = 16'hD100; win_hi = 16'hD19F;
    trigger(8'hF1);
    snapshot();
    wait_done("remap_timeout", 400);
    chk("remap_rd_in",  32'(rd_in - rin_base), 32'd160);
    chk("remap_rd_out", 32'(rd_out - rout_base), 32'd0);
    chk("remap_done_cyc", 32'(done_cyc - e0), 32'd322);
    chk_oam("remap_oam", 8'h33);

    // Reset in cycle E0+100 (READ of byte 49), then a clean transfer.
    clear_oam();
    win_lo = 16'hC000; win_hi = 16'hC09F;
    trigger(8'hC0);
    snapshot();
    repeat (99) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strb", 32'({bus_re, bus_we}), 32'd0);
    chk("midrst_addr", 32'(bus_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - done_base), 32'd0);
    chk("midrst_oam48", 32'(oam[48]), 32'(8'd48 ^ 8'h5A));
    chk("midrst_oam49", 32'(oam[49]), 32'd0);
    trigger(8'hC0);
    snapshot();
    wait_done("postrst_timeout", 400);
    chk("postrst_done_cyc", 32'(done_cyc - e0), 32'd322);
    chk_oam("postrst_oam", 8'h5A);

    // Second dma_wr with 0xC1 at E0+50.
    clear_oam();
    win_lo = 16'h0000; win_hi = 16'hFFFF;
    trigger(8'hC0);
    snapshot();
    e0a = e0;
    repeat (49) @(negedge clk);
    trigger(8'hC1);
    wait_done("second_timeout", 800);
`ifdef OAM_DMA_RESTART_EN
    chk("second_done_cyc", 32'(done_cyc - e0), 32'd322);
    chk_oam("second_oam", 8'hA5);
`else
    chk("second_done_cyc", 32'(done_cyc - e0a), 32'd322);
    chk_oam("second_oam", 8'h5A);
`endif
    repeat (400) @(negedge clk);
    chk("second_done_cnt", 32'(done_cnt - done_base), 32'd1);

    // Back-to-back: new trigger in the cycle done is high.
    clear_oam();
    trigger(8'hC0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_timeout", 32'(n < 400), 32'd1);
    trigger(8'hC1);
    snapshot();
    chk("b2b_start_busy", 32'(busy), 32'd1);
    wait_done("b2b_timeout", 400);
    chk("b2b_done_cyc", 32'(done_cyc - e0), 32'd322);
    chk("b2b_busy_len", 32'(busy_cnt - busy_base), 32'd321);
    chk_oam("b2b_oam", 8'hA5);

    chk("never_overlap", 32'(ovl_cnt), 32'd0);
    chk("no_stray_writes", 32'(oob_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
